// File: rtl/pong_pkg.sv
// Shared Pong engine definitions: match state encodings, paddle modes,
// ball direction constants and the millisecond-to-tick helper used by the
// match, paddle and ball blocks.
package pong_pkg;

  // Wide enough for 5 s at the 25.175 MHz pixel clock.
  localparam int CNT_W = 27;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4,
    ST_PAUSE      = 3'd5
  } match_state_e;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_1P   = 2'd1;
  localparam logic [1:0] MODE_2P   = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Countdown reload value for a delay of 'ms' milliseconds: a counter loaded
  // with this value and stepped down to zero spans exactly that many ms.
  function automatic logic [CNT_W-1:0] ms_to_ticks(input int unsigned clk_hz,
                                                   input int unsigned ms);
    int unsigned t;
    t = (clk_hz / 1000) * ms - 1;
    return t[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// rising-edge detector; pulse_o is high for one clk_0 cycle per press.
module btn_sync_edge (
  input  logic clk_0,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q;

  // Synchronizer chain plus one history flop for the edge compare.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: idle / serve / play / point / game-over FSM, both
// scores, mode latch, and the enables that gate paddles and ball.
// Optional build macro PONG_PAUSE_EN adds a PAUSE state toggled by start.
module match_controller
  import pong_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 25_175_000,
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_MS    = 1000,
  parameter int unsigned GAMEOVER_MS = 3000
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [1:0] mode_sel,
  input  logic       sq_missed,
  input  logic       sq_xveldir,
  output logic       reset_game,
  output logic [1:0] mode_choice,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       ball_enable,
  output logic       serve_dir,
  output logic [1:0] winner,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] SERVE_TICKS    = ms_to_ticks(CLK_HZ, SERVE_MS);
  localparam logic [CNT_W-1:0] GAMEOVER_TICKS = ms_to_ticks(CLK_HZ, GAMEOVER_MS);
  localparam logic [3:0]       WIN            = WIN_SCORE[3:0];

  match_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic [1:0]       mode_choice_q;
  logic             reset_game_q;
  logic             ball_en_q;
  logic             serve_dir_q;
  logic [3:0]       score_p1_q, score_p2_q;
  logic [1:0]       winner_q;
  logic             miss_q;

  logic start_pulse;
  logic miss_edge;
  logic mode_ok;

  btn_sync_edge u_start (
    .clk_0   (clk_0),
    .rst     (rst),
    .btn_i   (start_btn),
    .pulse_o (start_pulse)
  );

  // Previous sq_missed level, so a held miss only scores once.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) miss_q <= 1'b0;
    else      miss_q <= sq_missed;
  end

  assign miss_edge = sq_missed & ~miss_q;
  assign mode_ok   = (mode_sel == MODE_1P) || (mode_sel == MODE_2P);

  // Match FSM; every output is registered here so paddles and ball see
  // glitch-free controls.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mode_q        <= MODE_NONE;
      mode_choice_q <= MODE_NONE;
      reset_game_q  <= 1'b1;
      ball_en_q     <= 1'b0;
      serve_dir_q   <= DIR_RIGHT;
      score_p1_q    <= 4'd0;
      score_p2_q    <= 4'd0;
      winner_q      <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pulse && mode_ok) begin
            mode_q        <= mode_sel;
            mode_choice_q <= mode_sel;
            score_p1_q    <= 4'd0;
            score_p2_q    <= 4'd0;
            winner_q      <= 2'd0;
            serve_dir_q   <= DIR_RIGHT;
            reset_game_q  <= 1'b1;
            cnt_q         <= SERVE_TICKS;
            state_q       <= ST_SERVE_WAIT;
          end
        end
        ST_SERVE_WAIT: begin
          // Paddles are recentred only during the first serve-wait cycle.
          reset_game_q <= 1'b0;
          if (cnt_q == '0) begin
            ball_en_q <= 1'b1;
            state_q   <= ST_PLAY;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PLAY: begin
          // A miss outranks a simultaneous start press.
          if (miss_edge) begin
            ball_en_q <= 1'b0;
            state_q   <= ST_POINT;
            if (sq_xveldir == DIR_LEFT) begin
              score_p2_q  <= (score_p2_q == 4'd15) ? score_p2_q : score_p2_q + 4'd1;
              serve_dir_q <= DIR_LEFT;
            end else begin
              score_p1_q  <= (score_p1_q == 4'd15) ? score_p1_q : score_p1_q + 4'd1;
              serve_dir_q <= DIR_RIGHT;
            end
          end
`ifdef PONG_PAUSE_EN
          else if (start_pulse) begin
            ball_en_q     <= 1'b0;
            mode_choice_q <= MODE_NONE;
            state_q       <= ST_PAUSE;
          end
`endif
        end
        ST_POINT: begin
          reset_game_q <= 1'b1;
          if (score_p1_q == WIN) begin
            winner_q <= 2'd1;
            cnt_q    <= GAMEOVER_TICKS;
            state_q  <= ST_GAME_OVER;
          end else if (score_p2_q == WIN) begin
            winner_q <= 2'd2;
            cnt_q    <= GAMEOVER_TICKS;
            state_q  <= ST_GAME_OVER;
          end else begin
            cnt_q   <= SERVE_TICKS;
            state_q <= ST_SERVE_WAIT;
          end
        end
        ST_GAME_OVER: begin
          if (cnt_q == '0) begin
            mode_choice_q <= MODE_NONE;
            state_q       <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef PONG_PAUSE_EN
        ST_PAUSE: begin
          if (start_pulse) begin
            ball_en_q     <= 1'b1;
            mode_choice_q <= mode_q;
            state_q       <= ST_PLAY;
          end
        end
`endif
        default: begin
          mode_choice_q <= MODE_NONE;
          reset_game_q  <= 1'b1;
          ball_en_q     <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign reset_game  = reset_game_q;
  assign mode_choice = mode_choice_q;
  assign score_p1    = score_p1_q;
  assign score_p2    = score_p2_q;
  assign ball_enable = ball_en_q;
  assign serve_dir   = serve_dir_q;
  assign winner      = winner_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: vector table, directed corner
// sequences and randomized stimulus against a behavioural match model.
`timescale 1ns/1ps
module tb_match_controller;
  import pong_pkg::*;

  localparam int CLK_HZ   = 10_000;
  localparam int WIN      = 11;
  localparam int SERVE_MS = 2;
  localparam int GO_MS    = 3;
  localparam int SRV_T    = CLK_HZ / 1000 * SERVE_MS - 1;
  localparam int GO_T     = CLK_HZ / 1000 * GO_MS - 1;
`ifdef PONG_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       sq_missed = 1'b0;
  logic       sq_xveldir = 1'b0;
  logic       reset_game, ball_enable, serve_dir;
  logic [1:0] mode_choice, winner;
  logic [3:0] score_p1, score_p2;
  logic [2:0] state_dbg;

  always #5 clk_0 = ~clk_0;

  match_controller #(
    .CLK_HZ(CLK_HZ), .WIN_SCORE(WIN), .SERVE_MS(SERVE_MS), .GAMEOVER_MS(GO_MS)
  ) dut (
    .clk_0(clk_0), .rst(rst), .start_btn(start_btn), .mode_sel(mode_sel),
    .sq_missed(sq_missed), .sq_xveldir(sq_xveldir), .reset_game(reset_game),
    .mode_choice(mode_choice), .score_p1(score_p1), .score_p2(score_p2),
    .ball_enable(ball_enable), .serve_dir(serve_dir), .winner(winner),
    .state_dbg(state_dbg)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER, M_PAUSE} mph_e;
  mph_e m_ph;
  int   m_mode, m_p1, m_p2, m_win, m_sdir, m_entry, cyc;
  logic h1, h2, h3, mprev;   // start_btn samples 1/2/3 edges back

  function automatic int exp_state(input mph_e p);
    case (p)
      M_IDLE:  return int'(ST_IDLE);
      M_SERVE: return int'(ST_SERVE_WAIT);
      M_PLAY:  return int'(ST_PLAY);
      M_POINT: return int'(ST_POINT);
      M_OVER:  return int'(ST_GAME_OVER);
      default: return int'(ST_PAUSE);
    endcase
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_sdir = 1;
    m_entry = -100; h1 = 0; h2 = 0; h3 = 0; mprev = 0;
  endtask

  // One rising edge: the start press reaches the FSM two samples later.
  task automatic model_edge();
    logic sp, me;
    cyc++;
    if (!rst) begin model_reset(); return; end
    sp = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = start_btn;
    me = sq_missed & ~mprev;
    mprev = sq_missed;
    case (m_ph)
      M_IDLE: if (sp && (mode_sel == 1 || mode_sel == 2)) begin
        m_mode = int'(mode_sel); m_p1 = 0; m_p2 = 0; m_win = 0; m_sdir = 1;
        m_ph = M_SERVE; m_entry = cyc;
      end
      M_SERVE: if (cyc == m_entry + SRV_T + 1) m_ph = M_PLAY;
      M_PLAY: if (me) begin
        if (!sq_xveldir) begin m_p2 = (m_p2 == 15) ? 15 : m_p2 + 1; m_sdir = 0; end
        else             begin m_p1 = (m_p1 == 15) ? 15 : m_p1 + 1; m_sdir = 1; end
        m_ph = M_POINT;
      end else if (PAUSE_EN && sp) m_ph = M_PAUSE;
      M_POINT: begin
        if (m_p1 == WIN)      begin m_win = 1; m_ph = M_OVER; end
        else if (m_p2 == WIN) begin m_win = 2; m_ph = M_OVER; end
        else                        m_ph = M_SERVE;
        m_entry = cyc;
      end
      M_OVER:  if (cyc == m_entry + GO_T + 1) m_ph = M_IDLE;
      default: if (sp) m_ph = M_PLAY;
    endcase
  endtask

  task automatic compare_all();
    check("state_dbg", state_dbg, exp_state(m_ph));
    check("reset_game", reset_game,
          int'(m_ph == M_IDLE || m_ph == M_OVER || (m_ph == M_SERVE && cyc == m_entry)));
    check("mode_choice", mode_choice, (m_ph == M_IDLE || m_ph == M_PAUSE) ? 0 : m_mode);
    check("score_p1", score_p1, m_p1);
    check("score_p2", score_p2, m_p2);
    check("ball_enable", ball_enable, int'(m_ph == M_PLAY));
    check("serve_dir", serve_dir, m_sdir);
    check("winner", winner, m_win);
  endtask

  task automatic step();
    @(posedge clk_0);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic press(input int n);
    start_btn = 1'b1;
    repeat (n) step();
    start_btn = 1'b0;
  endtask

  task automatic wait_play(output int n);
    n = 0;
    while (ball_enable !== 1'b1 && n < 200) begin step(); n++; end
    check("reached_play", ball_enable, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       st;
    logic [1:0] ms;
    logic       mi;
    logic [2:0] es;
    logic [1:0] emc;
    logic       erg;
    logic       ebe;
  } vec_t;

  function automatic vec_t mkv(input logic st, input logic [1:0] ms, input logic mi,
                               input logic [2:0] es, input logic [1:0] emc, input logic erg);
    vec_t v;
    v.st = st; v.ms = ms; v.mi = mi; v.es = es; v.emc = emc; v.erg = erg; v.ebe = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t tbl[15];
    int n;
    // invalid mode 3, invalid mode 0, then a valid mode-2 start
    tbl[0]  = mkv(1, 3, 0, ST_IDLE, 0, 1);
    tbl[1]  = mkv(1, 3, 0, ST_IDLE, 0, 1);
    tbl[2]  = mkv(1, 3, 0, ST_IDLE, 0, 1);
    tbl[3]  = mkv(0, 3, 0, ST_IDLE, 0, 1);
    tbl[4]  = mkv(1, 0, 0, ST_IDLE, 0, 1);
    tbl[5]  = mkv(1, 0, 0, ST_IDLE, 0, 1);
    tbl[6]  = mkv(1, 0, 0, ST_IDLE, 0, 1);
    tbl[7]  = mkv(0, 2, 0, ST_IDLE, 0, 1);
    tbl[8]  = mkv(0, 2, 0, ST_IDLE, 0, 1);
    tbl[9]  = mkv(1, 2, 0, ST_IDLE, 0, 1);
    tbl[10] = mkv(1, 2, 0, ST_IDLE, 0, 1);
    tbl[11] = mkv(1, 2, 0, ST_SERVE_WAIT, 2, 1);
    tbl[12] = mkv(0, 3, 0, ST_SERVE_WAIT, 2, 0);
    tbl[13] = mkv(0, 1, 1, ST_SERVE_WAIT, 2, 0);
    tbl[14] = mkv(0, 1, 0, ST_SERVE_WAIT, 2, 0);

    model_reset();
    cyc = 0;

    // Reset state
    repeat (2) @(posedge clk_0);
    #1;
    check("rst.state", state_dbg, 0);
    check("rst.reset_game", reset_game, 1);
    check("rst.mode_choice", mode_choice, 0);
    check("rst.ball_enable", ball_enable, 0);
    check("rst.serve_dir", serve_dir, 1);
    check("rst.scores", {score_p1, score_p2}, 0);
    check("rst.winner", winner, 0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      start_btn = tbl[i].st; mode_sel = tbl[i].ms; sq_missed = tbl[i].mi; sq_xveldir = 1'b0;
      step();
      check($sformatf("vec%0d.state", i), state_dbg, tbl[i].es);
      check($sformatf("vec%0d.mode", i), mode_choice, tbl[i].emc);
      check($sformatf("vec%0d.reset_game", i), reset_game, tbl[i].erg);
      check($sformatf("vec%0d.ball_en", i), ball_enable, tbl[i].ebe);
    end

    // Serve wait lasts SRV_T+1 cycles from entry (entry was vector 11).
    wait_play(n);
    check("serve_len", n + 3, SRV_T + 1);

    // Miss while ball moves left: P2 scores, POINT one cycle, serve left.
    sq_missed = 1'b1; sq_xveldir = 1'b0;
    step();
    check("miss.state", state_dbg, ST_POINT);
    check("miss.p2", score_p2, 1);
    check("miss.serve_dir", serve_dir, 0);
    sq_missed = 1'b0;
    step();
    check("point.next", state_dbg, ST_SERVE_WAIT);
    check("point.reset_game", reset_game, 1);
    step();
    check("serve.reset_game_low", reset_game, 0);

    // Run P1 up to 10, then the winning point.
    for (int k = 0; k < 10; k++) begin
      wait_play(n);
      sq_missed = 1'b1; sq_xveldir = 1'b1;
      step();
      sq_missed = 1'b0;
      step();
    end
    check("p1_ten", score_p1, 10);
    wait_play(n);
    sq_missed = 1'b1; sq_xveldir = 1'b1;
    step();
    check("win.p1", score_p1, 11);
    check("win.point", state_dbg, ST_POINT);
    sq_missed = 1'b0;
    step();
    check("win.state", state_dbg, ST_GAME_OVER);
    check("win.winner", winner, 1);
    n = 1;
    while (state_dbg != ST_IDLE && n < 200) begin
      start_btn = (n < 5);   // presses during game over are ignored
      step();
      n++;
    end
    start_btn = 1'b0;
    check("gameover_len", n - 1, GO_T + 1);
    check("idle.p1_held", score_p1, 11);
    check("idle.p2_held", score_p2, 1);
    check("idle.winner_held", winner, 1);
    check("idle.mode", mode_choice, 0);
    repeat (3) step();

    // Async reset in SERVE_WAIT after a point has been scored.
    mode_sel = 2'd1;
    press(3);
    wait_play(n);
    sq_missed = 1'b1; sq_xveldir = 1'b0;
    step();
    sq_missed = 1'b0;
    repeat (4) step();
    check("pre_rst.state", state_dbg, ST_SERVE_WAIT);
    #2 rst = 1'b0;
    #1;
    check("arst.state", state_dbg, 0);
    check("arst.reset_game", reset_game, 1);
    check("arst.mode", mode_choice, 0);
    check("arst.p2", score_p2, 0);
    check("arst.serve_dir", serve_dir, 1);
    check("arst.ball_en", ball_enable, 0);
    model_reset();
    sq_missed = 1'b1;   // held through and after reset
    step();
    rst = 1'b1;
    step();
    press(3);
    wait_play(n);
    repeat (5) step();
    check("held_miss.state", state_dbg, ST_PLAY);
    check("held_miss.scores", {score_p1, score_p2}, 0);
    sq_missed = 1'b0;
    step();

`ifdef PONG_PAUSE_EN
    press(3);
    check("pause.state", state_dbg, ST_PAUSE);
    check("pause.mode", mode_choice, 0);
    check("pause.ball_en", ball_enable, 0);
    repeat (2) step();
    sq_missed = 1'b1; sq_xveldir = 1'b1;
    step();
    sq_missed = 1'b0;
    step();
    check("pause.miss_ignored", score_p1, 0);
    check("pause.hold", state_dbg, ST_PAUSE);
    press(3);
    check("resume.state", state_dbg, ST_PLAY);
    check("resume.mode", mode_choice, 1);
    check("resume.ball_en", ball_enable, 1);
`else
    press(3);
    repeat (2) step();
    check("nopause.state", state_dbg, ST_PLAY);
    check("nopause.mode", mode_choice, 1);
`endif

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 7) == 0) mode_sel = 2'($urandom_range(0, 3));
      sq_missed  = ($urandom_range(0, 5) == 0);
      sq_xveldir = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 999) != 0);
      step();
    end
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/match_controller.md
# match_controller

Top-level game sequencer for the Pong engine. It owns the match state machine (idle, serve, play, point, game over), keeps both scores, and selects the game mode. It drives `reset_game` and `mode_choice` into both paddle controllers and `ball_enable`/`serve_dir` into the ball engine, so that every datapath in the game advances only when the match allows it.

## Interface
- `CLK_HZ`, 25_175_000, clk_0 frequency used to derive all delays
- `WIN_SCORE`, 11, score that ends the match (1..15)
- `SERVE_MS`, 1000, ball-held delay before each serve
- `GAMEOVER_MS`, 3000, time winner is displayed before returning to idle

Ports:
- `clk_0`  in  1  25.175 MHz pixel clock
- `rst`  in  1  asynchronous, active-low reset
- `start_btn`  in  1  raw, asynchronous start button, active-high
- `mode_sel`  in  2  switch value: 1 = one player vs AI, 2 = two players; 0 and 3 are invalid
- `sq_missed`  in  1  ball reached the left/right wall (clk_0 domain, level)
- `sq_xveldir`  in  1  ball horizontal direction: 0 = moving left, 1 = moving right
- `reset_game`  out  1  recentres paddles and AI
- `mode_choice`  out  2  mode driven to the paddle controllers; 0 freezes paddles
- `score_p1`, `score_p2`  out  4 each  player scores
- `ball_enable`  out  1  ball is allowed to move
- `serve_dir`  out  1  direction of the next serve, same encoding as `sq_xveldir`
- `winner`  out  2  0 = none, 1 = P1, 2 = P2
- `state_dbg`  out  3  current state encoding

## Operation
- States: IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER (plus PAUSE, see Configuration).
- IDLE: `reset_game`=1, `mode_choice`=0, `ball_enable`=0. The previous scores and winner stay visible.
  - On a start edge with `mode_sel` in {1,2}: latch `mode_sel` into `mode_choice`, clear the scores and `winner`, set `serve_dir`=1, go to SERVE_WAIT.
  - Starts with `mode_sel` 0 or 3 are ignored.
- SERVE_WAIT: `reset_game`=1 in the first cycle only, `ball_enable`=0. The delay counter loads SERVE_TICKS = CLK_HZ/1000*SERVE_MS − 1 and counts down; at 0 the block goes to PLAY.
- PLAY: `ball_enable`=1. On a miss edge (`sq_missed` high and low in the previous cycle):
  - If `sq_xveldir`=0, P2 scores; otherwise P1 scores.
  - The scorer's score increments and the block goes to POINT.
  - `serve_dir` points toward the player who conceded (P1 conceded → 0).
- POINT: single cycle, `ball_enable`=0.
  - If the new score equals WIN_SCORE: set `winner` and go to GAME_OVER.
  - Otherwise go to SERVE_WAIT.
- GAME_OVER: `ball_enable`=0 and `reset_game`=1. The counter loads GAMEOVER_TICKS; at 0 the block goes to IDLE. Start edges are ignored.
- Scores saturate at 15, which cannot be reached while WIN_SCORE ≤ 15.
- `mode_sel` changes after the start latch are ignored until the next IDLE start.
- Miss edges outside PLAY are ignored.

## Timing
- Reset values: state IDLE, `reset_game`=1, `mode_choice`=0, scores 0, `ball_enable`=0, `serve_dir`=1, `winner`=0, counter 0, synchronizers 0.
- Start path: `start_btn` passes through a 2-FF synchronizer and an edge-detect flop. The state changes on the 3rd rising clk_0 edge after `start_btn` rises, provided setup is met.
- Miss path: the score register updates on the first edge where the miss edge is seen. POINT lasts exactly one cycle, and the next state follows on the following edge.
- SERVE_WAIT lasts SERVE_TICKS+1 cycles. GAME_OVER lasts GAMEOVER_TICKS+1 cycles.
- The counter is 27 bits, which covers up to 5 s at CLK_HZ.
- If `rst` is asserted mid-operation, all outputs return to their reset values asynchronously. The match is lost and no partial score is retained.
- A miss and a start edge in the same PLAY cycle: the miss wins and the start is dropped.

## Configuration
- `PONG_PAUSE_EN` defined:
  - A start edge in PLAY enters PAUSE. In PAUSE, `ball_enable`=0 and `mode_choice`=0 so the paddles freeze.
  - The next start edge restores the latched mode and returns to PLAY.
  - Miss edges in PAUSE are ignored.
- `PONG_PAUSE_EN` undefined: PAUSE does not exist and start edges in PLAY are ignored.

## Structure
- Shared package `pong_pkg` holds:
  - the state encodings and `MODE_NONE`/`MODE_1P`/`MODE_2P`;
  - the `DIR_LEFT`/`DIR_RIGHT` direction constants;
  - the `ms_to_ticks` constant function, reused by the paddle and ball blocks.
- The one sub-module is `btn_sync_edge`: the 2-FF synchronizer plus rising-edge pulse, used for `start_btn`.

## Test plan
- Reset, then `start_btn` with `mode_sel`=2 → `mode_choice`=2 after 3 edges; `reset_game` is high for 1 cycle; `ball_enable` rises after SERVE_TICKS+1 cycles.
- `mode_sel`=3 with a start press → the block stays in IDLE and `mode_choice` stays 0.
- In PLAY, pulse `sq_missed` with `sq_xveldir`=0 → `score_p2` goes 0→1, POINT for 1 cycle, then SERVE_WAIT with `serve_dir`=0.
- Score P1 to 10, then a miss with `sq_xveldir`=1 → `score_p1`=11, `winner`=1, GAME_OVER; IDLE after GAMEOVER_TICKS+1 cycles with the scores held.
- Assert `rst` during SERVE_WAIT → all outputs return to their reset values immediately, and a held `sq_missed` after release does not score.
- With `PONG_PAUSE_EN`: start in PLAY → `mode_choice`=0, `ball_enable`=0, and a miss pulse is ignored; a second start restores mode 1 and PLAY.
